// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_ctrl_pkg
//  Brief    : Shared constants for the ALU frame sequencer: frame marker,
//             ALU op codes, response status codes and FSM state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package alu_ctrl_pkg;

   // Start-of-frame marker byte
   localparam logic [7:0] SOF = 8'hA5;

   // ALU operation codes
   localparam int OP_W = 6;
   localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
   localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
   localparam logic [OP_W-1:0] OP_AND = 6'b100100;
   localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
   localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
   localparam logic [OP_W-1:0] OP_NOR = 6'b100111;
   localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
   localparam logic [OP_W-1:0] OP_SRL = 6'b000010;

   // Response status codes
   localparam logic [1:0] STATUS_OK      = 2'd0;
   localparam logic [1:0] STATUS_BAD_CHK = 2'd1;
   localparam logic [1:0] STATUS_BAD_OP  = 2'd2;
   localparam logic [1:0] STATUS_TIMEOUT = 2'd3;

   // FSM state encoding
   localparam int STATE_W = 4;
   localparam logic [STATE_W-1:0] ST_IDLE     = 4'd0;
   localparam logic [STATE_W-1:0] ST_GET_A    = 4'd1;
   localparam logic [STATE_W-1:0] ST_GET_B    = 4'd2;
   localparam logic [STATE_W-1:0] ST_GET_OP   = 4'd3;
   localparam logic [STATE_W-1:0] ST_GET_CHK  = 4'd4;
   localparam logic [STATE_W-1:0] ST_EXEC     = 4'd5;
   localparam logic [STATE_W-1:0] ST_SEND_RES = 4'd6;
   localparam logic [STATE_W-1:0] ST_WAIT_RES = 4'd7;
   localparam logic [STATE_W-1:0] ST_SEND_STA = 4'd8;
   localparam logic [STATE_W-1:0] ST_WAIT_STA = 4'd9;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE     = ST_IDLE,
      S_GET_A    = ST_GET_A,
      S_GET_B    = ST_GET_B,
      S_GET_OP   = ST_GET_OP,
      S_GET_CHK  = ST_GET_CHK,
      S_EXEC     = ST_EXEC,
      S_SEND_RES = ST_SEND_RES,
      S_WAIT_RES = ST_WAIT_RES,
      S_SEND_STA = ST_SEND_STA,
      S_WAIT_STA = ST_WAIT_STA
   } state_t;

   // True when the op code is one the ALU implements
   function automatic logic op_is_legal(input logic [OP_W-1:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_XOR, OP_NOR, OP_SRA, OP_SRL: op_is_legal = 1'b1;
         default:                        op_is_legal = 1'b0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/byte_timeout_timer.sv
`default_nettype none
// ============================================================================
//  Module   : byte_timeout_timer
//  Brief    : Saturating inter-byte timer. Flags expiry once the count has
//             reached TIMEOUT_CYCLES-1 and holds there until cleared.
//  Revision : 1.0  initial release
// ============================================================================
module byte_timeout_timer #(
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int c_cnt_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

   logic [c_cnt_w-1:0] r_count;

   // Count while enabled; clear has priority; stop at the last value
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != c_last)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_expired = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/alu_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_frame_sequencer
//  Brief    : Collects a checksummed 5-byte command frame from the UART,
//             drives the ALU operands, and returns RESULT and STATUS bytes
//             through the UART tx start/done handshake.
//  Revision : 1.0  initial release
// ============================================================================
module alu_frame_sequencer
   import alu_ctrl_pkg::*;
#(
   parameter int DBIT           = 8,
   parameter int NB_OP          = 6,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_rx_done_tick,
   input  logic [DBIT-1:0]  i_rx_data,
   input  logic [DBIT-1:0]  i_alu_data_in,
   input  logic             i_tx_done_tick,
   output logic [DBIT-1:0]  o_data_a,
   output logic [DBIT-1:0]  o_data_b,
   output logic [NB_OP-1:0] o_operation,
   output logic             o_tx_start,
   output logic [DBIT-1:0]  o_data_out,
   output logic             o_busy
);

   state_t            r_state;
   state_t            w_state_next;
   logic              r_exec_second;
   logic [DBIT-1:0]   r_a_sh;
   logic [DBIT-1:0]   r_b_sh;
   logic [NB_OP-1:0]  r_op_sh;
   logic [DBIT-1:0]   r_chk_acc;
   logic [1:0]        r_status;
   logic [DBIT-1:0]   r_result;
   logic [DBIT-1:0]   r_data_a;
   logic [DBIT-1:0]   r_data_b;
   logic [NB_OP-1:0]  r_operation;
   logic              w_in_frame;
   logic              w_timer_clear;
   logic              w_expired;
   logic [1:0]        w_chk_status;

   assign w_in_frame = (r_state == S_GET_A) || (r_state == S_GET_B) ||
                       (r_state == S_GET_OP) || (r_state == S_GET_CHK);

   // Timer restarts on every accepted byte and is held at zero while idle
   assign w_timer_clear = (r_state == S_IDLE) || (w_in_frame && i_rx_done_tick);

   // Checksum mismatch outranks an illegal op code
   assign w_chk_status = (i_rx_data != r_chk_acc)   ? STATUS_BAD_CHK :
                         op_is_legal(r_op_sh)        ? STATUS_OK      :
                                                       STATUS_BAD_OP;

   byte_timeout_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_clear   (w_timer_clear),
      .i_enable  (w_in_frame),
      .o_expired (w_expired)
   );

   // State register
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_state_next;
   end

   // Next-state and handshake outputs; a received byte beats timer expiry
   always_comb begin
      w_state_next = r_state;
      o_tx_start   = 1'b0;
      o_data_out   = '0;
      o_busy       = (r_state != S_IDLE);
      case (r_state)
         S_IDLE:     if (i_rx_done_tick && (i_rx_data == SOF)) w_state_next = S_GET_A;
         S_GET_A:    if (i_rx_done_tick) w_state_next = S_GET_B;
                     else if (w_expired) w_state_next = S_EXEC;
         S_GET_B:    if (i_rx_done_tick) w_state_next = S_GET_OP;
                     else if (w_expired) w_state_next = S_EXEC;
         S_GET_OP:   if (i_rx_done_tick) w_state_next = S_GET_CHK;
                     else if (w_expired) w_state_next = S_EXEC;
         S_GET_CHK:  if (i_rx_done_tick || w_expired) w_state_next = S_EXEC;
         S_EXEC:     if (r_exec_second) w_state_next = S_SEND_RES;
         S_SEND_RES: begin
            o_tx_start   = 1'b1;
            o_data_out   = r_result;
            w_state_next = S_WAIT_RES;
         end
         S_WAIT_RES: begin
            o_data_out = r_result;
            if (i_tx_done_tick) w_state_next = S_SEND_STA;
         end
         S_SEND_STA: begin
            o_tx_start   = 1'b1;
            o_data_out   = {{(DBIT-2){1'b0}}, r_status};
            w_state_next = S_WAIT_STA;
         end
         S_WAIT_STA: begin
            o_data_out = {{(DBIT-2){1'b0}}, r_status};
            if (i_tx_done_tick) w_state_next = S_IDLE;
         end
         default:    w_state_next = S_IDLE;
      endcase
   end

   // Frame capture, checksum accumulation, status and ALU operand/result staging
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_exec_second <= 1'b0;
         r_a_sh        <= '0;
         r_b_sh        <= '0;
         r_op_sh       <= '0;
         r_chk_acc     <= '0;
         r_status      <= STATUS_OK;
         r_result      <= '0;
         r_data_a      <= '0;
         r_data_b      <= '0;
         r_operation   <= '0;
      end else begin
         r_exec_second <= (r_state == S_EXEC) && !r_exec_second;
         if (w_in_frame && !i_rx_done_tick && w_expired) begin
            r_status <= STATUS_TIMEOUT;
         end
         case (r_state)
            S_IDLE: if (i_rx_done_tick && (i_rx_data == SOF)) r_chk_acc <= '0;
            S_GET_A: if (i_rx_done_tick) begin
               r_a_sh    <= i_rx_data;
               r_chk_acc <= r_chk_acc ^ i_rx_data;
            end
            S_GET_B: if (i_rx_done_tick) begin
               r_b_sh    <= i_rx_data;
               r_chk_acc <= r_chk_acc ^ i_rx_data;
            end
            S_GET_OP: if (i_rx_done_tick) begin
               r_op_sh   <= i_rx_data[NB_OP-1:0];
               r_chk_acc <= r_chk_acc ^ i_rx_data;
            end
            S_GET_CHK: if (i_rx_done_tick) r_status <= w_chk_status;
            S_EXEC: begin
               if (!r_exec_second) begin
                  if (r_status == STATUS_OK) begin
                     r_data_a    <= r_a_sh;
                     r_data_b    <= r_b_sh;
                     r_operation <= r_op_sh;
                  end
               end else begin
                  r_result <= (r_status == STATUS_OK) ? i_alu_data_in : '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_data_a    = r_data_a;
   assign o_data_b    = r_data_b;
   assign o_operation = r_operation;

endmodule
`default_nettype wire

// File: tb/tb_alu_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_frame_sequencer
//  Brief    : Bench for alu_frame_sequencer with a behavioural ALU, a tx
//             responder answering 4 clocks after each start, and a frame-level
//             reference model for the expected response bytes.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_frame_sequencer;
   import alu_ctrl_pkg::*;

   localparam int DBIT = 8;
   localparam int NB_OP = 6;
   localparam int TMO = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic             rx_tick;
   logic [DBIT-1:0]  rx_data;
   logic [DBIT-1:0]  alu_y;
   logic             tx_done;
   logic [DBIT-1:0]  data_a;
   logic [DBIT-1:0]  data_b;
   logic [NB_OP-1:0] operation;
   logic             tx_start;
   logic [DBIT-1:0]  data_out;
   logic             busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_tick_cyc = 0;
   int first_start_cyc = 0;
   int tx_cnt = 0;
   logic [7:0] tx_q[$];
   int         tx_cyc_q[$];
   logic [7:0] exp_a = 8'h00, exp_b = 8'h00;
   logic [5:0] exp_op = 6'h00;
   logic [5:0] legal_ops [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                 6'b100110, 6'b100111, 6'b000011, 6'b000010};

   alu_frame_sequencer #(
      .DBIT (DBIT), .NB_OP (NB_OP), .TIMEOUT_CYCLES (TMO)
   ) dut (
      .i_clk (clk), .i_reset (reset), .i_rx_done_tick (rx_tick), .i_rx_data (rx_data),
      .i_alu_data_in (alu_y), .i_tx_done_tick (tx_done),
      .o_data_a (data_a), .o_data_b (data_b), .o_operation (operation),
      .o_tx_start (tx_start), .o_data_out (data_out), .o_busy (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural ALU
   function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
      logic signed [7:0] sa;
      sa = a;
      case (op)
         6'b100000: alu_f = a + b;
         6'b100010: alu_f = a - b;
         6'b100100: alu_f = a & b;
         6'b100101: alu_f = a | b;
         6'b100110: alu_f = a ^ b;
         6'b100111: alu_f = ~(a | b);
         6'b000011: alu_f = sa >>> b;
         6'b000010: alu_f = a >> b;
         default:   alu_f = 8'h00;
      endcase
   endfunction

   assign alu_y = alu_f(data_a, data_b, operation);

   // Frame-level reference: expected status code of a complete frame
   function automatic logic [1:0] ref_status(input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] opb, input logic [7:0] ck);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 8; i++) if (legal_ops[i] == opb[5:0]) found = 1'b1;
      if (ck != (a ^ b ^ opb)) ref_status = 2'd1;
      else if (!found)         ref_status = 2'd2;
      else                     ref_status = 2'd0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // tx responder: records each started byte, answers done 4 clocks later
   always @(negedge clk) begin
      if (reset) begin
         tx_cnt  = 0;
         tx_done = 1'b0;
      end else begin
         logic pending;
         pending = (tx_cnt > 0);
         tx_done = 1'b0;
         if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) tx_done = 1'b1;
         end
         if (tx_start) begin
            chk("tx_start_before_done", {31'd0, pending}, 32'd0);
            tx_q.push_back(data_out);
            tx_cyc_q.push_back(cyc);
            tx_cnt = 4;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_tick = 1'b1;
      last_tick_cyc = cyc;
      @(negedge clk);
      rx_tick = 1'b0;
   endtask

   task automatic gap(input int max_gap);
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] opb, input logic [7:0] ck, input int max_gap);
      send_byte(SOF); gap(max_gap);
      send_byte(a);   gap(max_gap);
      send_byte(b);   gap(max_gap);
      send_byte(opb); gap(max_gap);
      send_byte(ck);
   endtask

   task automatic expect_resp(input string tag, input logic [7:0] res, input logic [7:0] sta);
      int w;
      w = 0;
      while ((tx_q.size() < 2 || busy) && w < 300) begin
         @(negedge clk);
         w++;
      end
      chk({tag, "_tx_count"}, tx_q.size(), 2);
      if (tx_q.size() >= 2) begin
         chk({tag, "_result"}, {24'd0, tx_q[0]}, {24'd0, res});
         chk({tag, "_status"}, {24'd0, tx_q[1]}, {24'd0, sta});
         first_start_cyc = tx_cyc_q[0];
      end
      tx_q.delete();
      tx_cyc_q.delete();
   endtask

   task automatic check_operands(input string tag);
      chk({tag, "_data_a"}, {24'd0, data_a}, {24'd0, exp_a});
      chk({tag, "_data_b"}, {24'd0, data_b}, {24'd0, exp_b});
      chk({tag, "_operation"}, {26'd0, operation}, {26'd0, exp_op});
   endtask

   task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] opb, input logic [7:0] ck, input int max_gap);
      logic [1:0] st;
      logic [7:0] res;
      st  = ref_status(a, b, opb, ck);
      res = (st == 2'd0) ? alu_f(a, b, opb[5:0]) : 8'h00;
      send_frame(a, b, opb, ck, max_gap);
      expect_resp(tag, res, {6'd0, st});
      if (st == 2'd0) begin
         exp_a = a; exp_b = b; exp_op = opb[5:0];
      end
      check_operands(tag);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] ra, rb, ro, rc, flip;
      int kind;
      reset = 1'b1; rx_tick = 1'b0; rx_data = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_tx_start", {31'd0, tx_start}, 32'd0);
      chk("reset_data_out", {24'd0, data_out}, 32'd0);
      check_operands("reset");
      reset = 1'b0;
      @(negedge clk);

      // Directed frames
      run_frame("t1_or", 8'h96, 8'h69, 8'h25, 8'hDA, 0);
      run_frame("t2_sub", 8'h15, 8'h22, 8'hE2, 8'hD5, 0);
      chk("t2_latency", first_start_cyc - last_tick_cyc, 3);
      run_frame("t3_bad_chk", 8'h01, 8'h02, 8'h20, 8'h00, 0);
      run_frame("t4_bad_op", 8'h01, 8'h02, 8'h3F, 8'h3C, 0);

      // Non-SOF bytes while idle are dropped
      send_byte(8'h11);
      chk("idle_junk_busy1", {31'd0, busy}, 32'd0);
      send_byte(8'h22);
      chk("idle_junk_busy2", {31'd0, busy}, 32'd0);
      repeat (20) @(negedge clk);
      chk("idle_junk_no_tx", tx_q.size(), 0);

      // Stalled frame times out
      send_byte(SOF);
      send_byte(8'h01);
      expect_resp("t5_timeout", 8'h00, 8'h03);
      check_operands("t5_timeout");
      run_frame("t5_after", 8'h30, 8'h0C, 8'h24, 8'h30 ^ 8'h0C ^ 8'h24, 1);

      // Byte arriving exactly on the expiry cycle keeps the frame alive
      send_byte(SOF);
      send_byte(8'h01);
      repeat (TMO - 1) @(negedge clk);
      send_byte(8'h02);
      send_byte(8'h20);
      send_byte(8'h23);
      expect_resp("t5_edge", 8'h03, 8'h00);
      exp_a = 8'h01; exp_b = 8'h02; exp_op = 6'h20;
      check_operands("t5_edge");

      // Reset during WAIT_RES
      send_frame(8'h5A, 8'h33, 8'hA6, 8'h5A ^ 8'h33 ^ 8'hA6, 0);
      for (int w = 0; w < 100 && tx_q.size() < 1; w++) @(negedge clk);
      chk("t6_first_byte", tx_q.size(), 1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      tx_q.delete();
      tx_cyc_q.delete();
      chk("t6_busy", {31'd0, busy}, 32'd0);
      chk("t6_tx_start", {31'd0, tx_start}, 32'd0);
      chk("t6_data_out", {24'd0, data_out}, 32'd0);
      exp_a = 8'h00; exp_b = 8'h00; exp_op = 6'h00;
      check_operands("t6_reset");
      @(negedge clk);
      reset = 1'b0;
      repeat (30) @(negedge clk);
      chk("t6_no_status", tx_q.size(), 0);
      run_frame("t6_after", 8'h7F, 8'h01, 8'h20, 8'h7F ^ 8'h01 ^ 8'h20, 0);

      // Randomized frames
      for (int n = 0; n < 30; n++) begin
         ra = 8'($urandom); rb = 8'($urandom);
         kind = $urandom_range(0, 9);
         if (kind == 1) ro = 8'($urandom);
         else ro = {2'($urandom), legal_ops[$urandom_range(0, 7)]};
         rc = ra ^ rb ^ ro;
         if (kind == 0) begin
            flip = 8'h01 << $urandom_range(0, 7);
            rc = rc ^ flip;
         end
         run_frame("rand", ra, rb, ro, rc, 3);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
